reset_sequencer: RTL and testbench

// - Parametrised per-peripheral reset controller; successor of the fixed 10-line soft-reset block.
// - Holds NCH peripheral resets; releases them one at a time after global reset (staggered, low inrush).
// - CPU-writable hold mask, self-clearing reset pulses and readback on a small MMIO window.
// - Sits on the SoC bus next to the interrupt/timer blocks; drives rst_* of gpio, uart, sdcard, etc.

---
 rtl/reset_sequencer.sv | 171 +++++++++++++++++
 tb/tb_reset_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// reset_sequencer: staggered per-channel reset release, CPU hold mask, self-clearing pulses.
// Optional watchdog re-sequencing is compiled in with `define RESET_WDT_EN.
module reset_sequencer #(
  parameter int NCH       = 10,
  parameter int STAGGER   = 16,
  parameter int PULSE_W   = 8,
  parameter int PULSE_CYC = 32
`ifdef RESET_WDT_EN
  ,
  parameter int WDT_W     = 24
`endif
) (
  input  logic           clk,
  input  logic           rst_globl,
  input  logic [2:0]     a,
  input  logic [31:0]    d,
  input  logic           we,
  output logic [31:0]    spo,
  output logic [NCH-1:0] rst_out,
  output logic           seq_done
);
  localparam int SCW = (STAGGER > 1) ? $clog2(STAGGER) : 1;
  localparam logic [SCW-1:0]     SEQ_LAST   = SCW'(STAGGER - 1);
  localparam logic [PULSE_W-1:0] PULSE_LOAD = PULSE_W'(PULSE_CYC);

  typedef enum logic {S_SEQ = 1'b0, S_RUN = 1'b1} state_t;

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  state_t             state_q, state_d;
  logic [NCH-1:0]     hold_q, hold_d;
  logic [NCH-1:0]     rst_out_q, rst_out_d;
  logic [NCH-1:0]     seq_mask_s, pulse_on_s;
  logic [PULSE_W-1:0] pcnt_q [NCH];
  logic [PULSE_W-1:0] pcnt_d [NCH];
  logic [7:0]         seq_idx_q, seq_idx_d;
  logic [SCW-1:0]     seq_cnt_q, seq_cnt_d;
  logic               seq_done_q, seq_done_d;
  logic [31:0]        data_s, rd_s;
  logic               wr_hold_s, wr_pulse_s;
`ifdef RESET_WDT_EN
  logic               wdt_en_q, wdt_en_d, wr_wdt_s;
  logic [WDT_W-1:0]   wdt_cnt_q, wdt_cnt_d;
  assign wr_wdt_s = we && (a == 3'd4);
`endif

  assign data_s     = bswap(d);
  assign wr_hold_s  = we && (a == 3'd0) && (state_q == S_RUN);
  assign wr_pulse_s = we && (a == 3'd1) && (state_q == S_RUN);

  if (NCH < 32) begin : g_unused
    logic unused_hi;
    assign unused_hi = ^data_s[31:NCH];
  end

  always_ff @(posedge clk or posedge rst_globl) begin
    if (rst_globl) begin
      state_q    <= S_SEQ;
      hold_q     <= '1;
      rst_out_q  <= '1;
      seq_idx_q  <= '0;
      seq_cnt_q  <= '0;
      seq_done_q <= 1'b0;
      for (int i = 0; i < NCH; i++) pcnt_q[i] <= '0;
`ifdef RESET_WDT_EN
      wdt_en_q   <= 1'b0;
      wdt_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      rst_out_q  <= rst_out_d;
      seq_idx_q  <= seq_idx_d;
      seq_cnt_q  <= seq_cnt_d;
      seq_done_q <= seq_done_d;
      for (int i = 0; i < NCH; i++) pcnt_q[i] <= pcnt_d[i];
`ifdef RESET_WDT_EN
      wdt_en_q   <= wdt_en_d;
      wdt_cnt_q  <= wdt_cnt_d;
`endif
    end
  end

  // rst_out is built from next-state values so a write shows on the very next edge
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    seq_idx_d  = seq_idx_q;
    seq_cnt_d  = seq_cnt_q;
    seq_done_d = seq_done_q;
    seq_mask_s = '0;
    pulse_on_s = '0;
    for (int i = 0; i < NCH; i++) begin
      if (wr_pulse_s && data_s[i]) begin
        pcnt_d[i] = PULSE_LOAD;
      end else if (pcnt_q[i] != '0) begin
        pcnt_d[i] = pcnt_q[i] - PULSE_W'(1);
      end else begin
        pcnt_d[i] = pcnt_q[i];
      end
    end
    case (state_q)
      S_SEQ: begin
        hold_d = '0;
        if (seq_cnt_q == SEQ_LAST) begin
          seq_cnt_d = '0;
          seq_idx_d = seq_idx_q + 8'd1;
        end else begin
          seq_cnt_d = seq_cnt_q + SCW'(1);
        end
        if (seq_idx_d == 8'(NCH)) begin
          state_d    = S_RUN;
          seq_done_d = 1'b1;
        end else begin
          state_d    = S_SEQ;
        end
      end
      S_RUN: begin
        if (wr_hold_s) hold_d = data_s[NCH-1:0];
        else           hold_d = hold_q;
      end
      default: state_d = S_SEQ;
    endcase
`ifdef RESET_WDT_EN
    wdt_en_d  = wdt_en_q;
    wdt_cnt_d = wdt_cnt_q;
    if (wr_wdt_s) begin
      wdt_cnt_d = '1;
      wdt_en_d  = data_s[0];
    end else if (wdt_en_q && (state_q == S_RUN)) begin
      if (wdt_cnt_q == '0) begin
        wdt_en_d   = 1'b0;
        hold_d     = '1;
        state_d    = S_SEQ;
        seq_idx_d  = '0;
        seq_cnt_d  = '0;
        seq_done_d = 1'b0;
      end else begin
        wdt_cnt_d  = wdt_cnt_q - WDT_W'(1);
      end
    end else begin
      wdt_cnt_d = wdt_cnt_q;
    end
`endif
    for (int i = 0; i < NCH; i++) begin
      seq_mask_s[i] = (state_d == S_SEQ) && (i >= int'(seq_idx_d));
      pulse_on_s[i] = (pcnt_d[i] != '0);
    end
    rst_out_d = hold_d | pulse_on_s | seq_mask_s;
  end

  // MMIO readback, combinational from the address
  always_comb begin
    rd_s = 32'd0;
    case (a)
      3'd0: rd_s = 32'(hold_q);
      3'd2: rd_s = 32'(rst_out_q);
      3'd3: rd_s = {seq_done_q, 23'd0, seq_idx_q};
`ifdef RESET_WDT_EN
      3'd4: rd_s = {31'd0, wdt_en_q};
`endif
      default: rd_s = 32'd0;
    endcase
    spo = bswap(rd_s);
  end

  assign rst_out  = rst_out_q;
  assign seq_done = seq_done_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: stimulus queues timed expectations, a negedge
// monitor pops and compares them when their cycle comes up.
module tb_reset_sequencer;
  localparam int NCH = 10;

  logic              clk = 1'b0;
  logic              rst_globl = 1'b1;
  logic [2:0]        a = 3'd0;
  logic [31:0]       d = 32'd0;
  logic              we = 1'b0;
  logic [31:0]       spo;
  logic [NCH-1:0]    rst_out;
  logic              seq_done;

  typedef struct {
    int          cyc;
    int          kind;
    int          tag;
    logic [31:0] exp;
  } item_t;

  item_t sb[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int ntag = 0;
  int t0, t1, p, q, r, s, w;

  reset_sequencer #(
    .NCH(NCH), .STAGGER(16), .PULSE_W(8), .PULSE_CYC(32)
`ifdef RESET_WDT_EN
    , .WDT_W(8)
`endif
  ) dut (
    .clk(clk), .rst_globl(rst_globl), .a(a), .d(d), .we(we),
    .spo(spo), .rst_out(rst_out), .seq_done(seq_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic string kname(input int k);
    case (k)
      0: return "rst_out";
      1: return "seq_done";
      default: return "spo";
    endcase
  endfunction

  task automatic push(input int kind, input int c, input logic [31:0] exp);
    item_t it;
    it.cyc = c; it.kind = kind; it.tag = ntag; it.exp = exp;
    ntag++;
    sb.push_back(it);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick(1);
  endtask

  task automatic wr(input logic [2:0] addr, input logic [31:0] val);
    a = addr; d = val; we = 1'b1;
    tick(1);
    we = 1'b0; d = 32'd0;
  endtask

  task automatic rd(input logic [2:0] addr, input logic [31:0] exp);
    a = addr;
    push(2, cyc, exp);
    tick(1);
  endtask

  always @(negedge clk) begin : mon
    int k;
    logic [31:0] act;
    k = 0;
    while (k < sb.size()) begin
      if (sb[k].cyc <= cyc) begin
        case (sb[k].kind)
          0: act = 32'(rst_out);
          1: act = {31'd0, seq_done};
          default: act = spo;
        endcase
        checks++;
        if (sb[k].cyc < cyc || act !== sb[k].exp) begin
          errors++;
          $display("FAIL %s #%0d cyc=%0d due=%0d actual=%h required=%h",
                   kname(sb[k].kind), sb[k].tag, cyc, sb[k].cyc, act, sb[k].exp);
        end
        sb.delete(k);
      end else begin
        k++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout cyc=%0d actual=running required=finished", cyc);
    $fatal(1);
  end

  initial begin
    tick(3);
    push(0, cyc, 32'h3FF);
    push(1, cyc, 32'd0);
    rd(0, bswap(32'h3FF));

    rst_globl = 1'b0;
    t0 = cyc;
    push(0, t0 + 15, 32'h3FF);
    push(0, t0 + 16, 32'h3FE);
    push(0, t0 + 32, 32'h3FC);
    push(0, t0 + 159, 32'h200);
    push(1, t0 + 159, 32'd0);
    push(0, t0 + 160, 32'd0);
    push(1, t0 + 160, 32'd1);
    wait_until(t0 + 40);
    wr(0, bswap(32'h5));
    push(0, cyc, 32'h3FC);
    rd(0, 32'd0);
    rd(3, bswap(32'h2));

    wait_until(t0 + 170);
    rd(3, bswap(32'h8000000A));
    wr(0, bswap(32'h5));
    push(0, cyc, 32'h005);
    rd(0, bswap(32'h5));
    rd(2, bswap(32'h5));
    wr(0, 32'd0);
    push(0, cyc, 32'd0);

    wr(1, bswap(32'h8));
    p = cyc;
    push(0, p, 32'h8);
    push(2, p, 32'd0);
    push(0, p + 31, 32'h8);
    push(0, p + 32, 32'd0);
    wait_until(p + 33);

    wr(1, bswap(32'h8));
    q = cyc;
    push(0, q, 32'h8);
    push(0, q + 32, 32'h8);
    push(0, q + 51, 32'h8);
    push(0, q + 52, 32'd0);
    wait_until(q + 19);
    wr(1, bswap(32'h8));
    wait_until(q + 53);

    wr(1, bswap(32'h8));
    r = cyc;
    push(0, r + 31, 32'h8);
    push(0, r + 32, 32'h8);
    push(0, r + 33, 32'h8);
    wait_until(r + 31);
    wr(0, bswap(32'h8));
    tick(2);
    wr(0, 32'd0);
    push(0, cyc, 32'd0);

    wr(0, 32'hFFFFFFFF);
    push(0, cyc, 32'h3FF);
    rd(0, bswap(32'h3FF));
    wr(0, 32'd0);
    wr(5, 32'hFFFFFFFF);
    push(0, cyc, 32'd0);
    rd(5, 32'd0);
    rd(7, 32'd0);
    rd(1, 32'd0);
`ifndef RESET_WDT_EN
    rd(4, 32'd0);
`endif

    wr(1, bswap(32'h201));
    s = cyc;
    push(0, s, 32'h201);
    tick(5);
    rst_globl = 1'b1;
    push(0, cyc, 32'h3FF);
    push(1, cyc, 32'd0);
    tick(1);
    rd(0, bswap(32'h3FF));
    rst_globl = 1'b0;
    t1 = cyc;
    push(0, t1 + 15, 32'h3FF);
    push(0, t1 + 16, 32'h3FE);
    push(1, t1 + 159, 32'd0);
    push(0, t1 + 160, 32'd0);
    push(1, t1 + 160, 32'd1);
    wait_until(t1 + 5);
    rd(3, 32'd0);
    wait_until(t1 + 161);

`ifdef RESET_WDT_EN
    wr(4, bswap(32'h1));
    w = cyc;
    push(2, w, bswap(32'h1));
    push(0, w + 255, 32'd0);
    push(0, w + 256, 32'h3FF);
    push(1, w + 256, 32'd0);
    push(0, w + 271, 32'h3FF);
    push(0, w + 272, 32'h3FE);
    push(0, w + 416, 32'd0);
    push(1, w + 416, 32'd1);
    wait_until(w + 260);
    rd(4, 32'd0);
    wait_until(w + 420);
`endif

    for (int i = 0; i < 20 && sb.size() > 0; i++) tick(1);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
